regs_wb_arbiter: RTL and testbench

REGS_WB_ARBITER -- requirements
Module: regs_wb_arbiter

---
 rtl/regs_wb_arbiter_pkg.sv | 27 ++
 rtl/regs_wb_fifo.sv | 74 +++++++
 rtl/regs_wb_arbiter.sv | 139 +++++++++++++
 tb/tb_regs_wb_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/regs_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter.
//   arb_state_t : arbitration FSM state (NORMAL / FORCE_B)
//   wb_req_t    : one writeback request, destination register + value
//   WB_W        : packed width of wb_req_t
//   addr_onehot : register-number to busy-bit decode; x0 never maps to a bit
package regs_wb_arbiter_pkg;

    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_FORCE_B = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_req_t;

    localparam int WB_W = $bits(wb_req_t);

    function automatic logic [31:0] addr_onehot(input logic [4:0] addr);
        logic [31:0] m;
        m    = 32'h1 << addr;
        m[0] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/regs_wb_fifo.sv
// In-order buffer for long-latency writebacks.
//   clk, rst    : clock, asynchronous active-high reset (empties the buffer)
//   push_valid  : push request; taken when the buffer is not full
//   push_req    : {addr, data} to push
//   pop         : pop strobe for the head entry (ignored when empty)
//   head        : oldest entry, combinational read
//   empty, full : occupancy flags
//   addr_mask   : OR of one-hot(addr) over every occupied entry
module regs_wb_fifo
    import regs_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_valid,
    input  logic [WB_W-1:0] push_req,
    input  logic            pop,
    output logic [WB_W-1:0] head,
    output logic            empty,
    output logic            full,
    output logic [31:0]     addr_mask
);

    localparam int AW = $clog2(DEPTH);

    logic [WB_W-1:0] mem [DEPTH];
    // One extra pointer bit separates "full" from "empty" when indices match.
    logic [AW:0]     wr_ptr_reg;
    logic [AW:0]     rd_ptr_reg;
    logic [AW:0]     count;
    logic            push_fire;
    logic            pop_fire;
    logic [31:0]     entry_mask [DEPTH];

    assign count     = wr_ptr_reg - rd_ptr_reg;
    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign push_fire = push_valid && !full;
    assign pop_fire  = pop && !empty;
    assign head      = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_fire) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_fire)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) mem[wr_ptr_reg[AW-1:0]] <= push_req;
    end

    // An entry is live when its distance from the read index (mod DEPTH)
    // is below the occupancy count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [AW-1:0] rel;
            assign rel            = AW'(gi) - rd_ptr_reg[AW-1:0];
            assign entry_mask[gi] = ({1'b0, rel} < count) ?
                                    addr_onehot(mem[gi][WB_W-1 -: 5]) : 32'h0;
        end
    endgenerate

    always_comb begin
        addr_mask = 32'h0;
        for (int i = 0; i < DEPTH; i++) addr_mask = addr_mask | entry_mask[i];
    end

endmodule

// File: rtl/regs_wb_arbiter.sv
// Two-port writeback arbiter in front of a single register-file write port.
// Port A (pipeline) wins by default; port B (long-latency unit) is buffered
// and forced through after STARVE_LIMIT consecutive losses.
//   clk, rst                  : clock, asynchronous active-high reset
//   a_valid/a_ready/a_addr/a_data : pipeline writeback handshake
//   b_valid/b_ready/b_addr/b_data : long-latency writeback handshake
//   w_regs_en/addr/data       : registered register-file write port
//   busy_mask                 : registers with a B write still in flight
module regs_wb_arbiter
    import regs_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int B_DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        w_regs_en,
    output logic [4:0]  w_regs_addr,
    output logic [31:0] w_regs_data,
    output logic [31:0] busy_mask
);

    localparam int CW = 4;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    arb_state_t      state_reg;
    arb_state_t      state_next;
    logic [CW-1:0]   starve_cnt_reg;
    logic [CW-1:0]   starve_cnt_next;
    logic            grant_a;
    logic            grant_b;
    wb_req_t         head_req;
    wb_req_t         grant_req;
    logic [WB_W-1:0] head_bits;
    logic            fifo_empty;
    logic            fifo_full;
    logic [31:0]     fifo_mask;
    logic            w_regs_en_reg;
    logic [4:0]      w_regs_addr_reg;
    logic [31:0]     w_regs_data_reg;
    logic            out_b_reg;

    regs_wb_fifo #(
        .DEPTH (B_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (b_valid),
        .push_req   ({b_addr, b_data}),
        .pop        (grant_b),
        .head       (head_bits),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .addr_mask  (fifo_mask)
    );

    assign head_req = head_bits;
    assign b_ready  = !rst && !fifo_full;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_NORMAL;
        else     state_reg <= state_next;
    end

    // FSM next state: enter FORCE_B on the same edge the loss count hits the
    // limit, so B is granted right after the LIMIT-th lost cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_NORMAL:  if (starve_cnt_next == LIMIT) state_next = ST_FORCE_B;
            ST_FORCE_B: state_next = ST_NORMAL;
            default:    state_next = ST_NORMAL;
        endcase
    end

    // FSM outputs: grants and A-side ready
    always_comb begin
        a_ready = 1'b0;
        grant_a = 1'b0;
        grant_b = 1'b0;
        case (state_reg)
            ST_NORMAL: begin
                a_ready = !rst;
                grant_a = a_valid;
                grant_b = !a_valid && !fifo_empty;
            end
            ST_FORCE_B: grant_b = !fifo_empty;
            default: ;
        endcase
    end

    // Consecutive cycles the B head has been passed over in favour of A.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (grant_b || fifo_empty)
            starve_cnt_next = '0;
        else if (grant_a && starve_cnt_reg < LIMIT)
            starve_cnt_next = starve_cnt_reg + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve_cnt_reg <= '0;
        else     starve_cnt_reg <= starve_cnt_next;
    end

    assign grant_req = grant_a ? wb_req_t'({a_addr, a_data}) : head_req;

    // Registered write port; x0 requests are consumed but never write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_regs_en_reg   <= 1'b0;
            w_regs_addr_reg <= '0;
            w_regs_data_reg <= '0;
            out_b_reg       <= 1'b0;
        end else begin
            w_regs_en_reg <= (grant_a || grant_b) && (grant_req.addr != 5'd0);
            out_b_reg     <= grant_b;
            if (grant_a || grant_b) begin
                w_regs_addr_reg <= grant_req.addr;
                w_regs_data_reg <= grant_req.data;
            end
        end
    end

    assign w_regs_en   = w_regs_en_reg;
    assign w_regs_addr = w_regs_addr_reg;
    assign w_regs_data = w_regs_data_reg;
    assign busy_mask   = fifo_mask | (out_b_reg ? addr_onehot(w_regs_addr_reg) : 32'h0);

endmodule

// File: tb/tb_regs_wb_arbiter.sv
module tb_regs_wb_arbiter;

    localparam int LIMIT = 4;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [4:0]  a_addr = '0;
    logic [31:0] a_data = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [4:0]  b_addr = '0;
    logic [31:0] b_data = '0;
    logic        w_regs_en;
    logic [4:0]  w_regs_addr;
    logic [31:0] w_regs_data;
    logic [31:0] busy_mask;

    regs_wb_arbiter #(
        .STARVE_LIMIT (LIMIT),
        .B_DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_addr      (a_addr),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_addr      (b_addr),
        .b_data      (b_data),
        .w_regs_en   (w_regs_en),
        .w_regs_addr (w_regs_addr),
        .w_regs_data (w_regs_data),
        .busy_mask   (busy_mask)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    int          checks   = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    // Reference model: pending B requests in arrival order, how many grants
    // in a row B has lost, and the B write currently in the output register.
    logic [36:0] b_q[$];
    int          losses = 0;
    logic [4:0]  out_b_addr = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] m;
        m = 32'h0;
        foreach (b_q[i]) m = m | (32'h1 << b_q[i][36:32]);
        m = m | (32'h1 << out_b_addr);
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic model_step(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                              input bit bv, input logic [4:0] ba, input logic [31:0] bd);
        bit          forced;
        bit          b_room;
        bit          took_a;
        bit          took_b;
        logic [36:0] g;
        exp_t        e;
        forced = (losses >= LIMIT);
        b_room = (b_q.size() < DEPTH);
        took_b = (b_q.size() > 0) && (forced || !av);
        took_a = !forced && av;
        g      = took_a ? {aa, ad} : (took_b ? b_q[0] : 37'h0);
        e.en   = (took_a || took_b) && (g[36:32] != 5'd0);
        e.addr = g[36:32];
        e.data = g[31:0];
        exp_q.push_back(e);
        if (took_b || b_q.size() == 0) losses = 0;
        else if (took_a && losses < LIMIT) losses++;
        out_b_addr = took_b ? g[36:32] : 5'd0;
        if (took_b) void'(b_q.pop_front());
        if (bv && b_room) b_q.push_back({ba, bd});
    endtask

    task automatic cycle(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                         input bit bv, input logic [4:0] ba, input logic [31:0] bd);
        @(negedge clk);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
        check("a_ready", {31'b0, a_ready}, {31'b0, losses < LIMIT});
        check("b_ready", {31'b0, b_ready}, {31'b0, b_q.size() < DEPTH});
        check("busy_mask", busy_mask, model_busy());
        model_step(av, aa, ad, bv, ba, bd);
    endtask

    // Monitor: one expected output per clock edge outside reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                check("w_regs_en_in_reset", {31'b0, w_regs_en}, 32'h0);
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("w_regs_en", {31'b0, w_regs_en}, {31'b0, e.en});
                if (e.en) begin
                    check("w_regs_addr", {27'b0, w_regs_addr}, {27'b0, e.addr});
                    check("w_regs_data", w_regs_data, e.data);
                    $display("write x%0d = %h", w_regs_addr, w_regs_data);
                end
            end
        end
    end

    initial begin
        logic [4:0] ra;
        #12;
        check("rst_w_regs_en", {31'b0, w_regs_en}, 32'h0);
        check("rst_w_regs_addr", {27'b0, w_regs_addr}, 32'h0);
        check("rst_w_regs_data", w_regs_data, 32'h0);
        check("rst_busy_mask", busy_mask, 32'h0);
        check("rst_a_ready", {31'b0, a_ready}, 32'h0);
        check("rst_b_ready", {31'b0, b_ready}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_step(0, 0, 0, 0, 0, 0);

        // A only, then B only
        cycle(1, 5'd5, 32'h0000_1234, 0, 0, 0);
        cycle(0, 0, 0, 1, 5'd7, 32'hDEAD_BEEF);
        repeat (3) cycle(0, 0, 0, 0, 0, 0);

        // Starvation: A every cycle, one B to x9
        cycle(1, 5'd1, 32'h1111_0000, 1, 5'd9, 32'h9999_9999);
        for (int i = 0; i < 7; i++) cycle(1, 5'(i + 2), 32'(i), 0, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 0, 0);

        // Full FIFO: A saturating, B pushing every cycle
        for (int i = 0; i < 10; i++) cycle(1, 5'(i + 10), 32'hA000 + 32'(i), 1, 5'(i + 20), 32'hB000 + 32'(i));
        repeat (6) cycle(0, 0, 0, 0, 0, 0);

        // x0 write from A
        cycle(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 0, 0);

        // Reset with two B entries pending and B being forced
        for (int i = 0; i < 8; i++) begin
            cycle(1, 5'd1, 32'(i), i < 2, 5'(3 + i), 32'hC000 + 32'(i));
            if (losses >= LIMIT) break;
        end
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        check("force_a_ready", {31'b0, a_ready}, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_w_regs_en", {31'b0, w_regs_en}, 32'h0);
        check("mid_rst_w_regs_addr", {27'b0, w_regs_addr}, 32'h0);
        check("mid_rst_w_regs_data", w_regs_data, 32'h0);
        check("mid_rst_busy_mask", busy_mask, 32'h0);
        check("mid_rst_b_ready", {31'b0, b_ready}, 32'h0);
        b_q.delete();
        exp_q.delete();
        losses = 0;
        out_b_addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_a_ready", {31'b0, a_ready}, 32'h1);
        check("post_rst_b_ready", {31'b0, b_ready}, 32'h1);
        model_step(0, 0, 0, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 1200; i++) begin
            ra = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) ra = 5'd0;
            cycle($urandom_range(0, 3) != 0, ra, $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
        end
        repeat (6) cycle(0, 0, 0, 0, 0, 0);

        @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
